// File: rtl/if_stage_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_prefetch_pkg
// Shared definitions for the prefetching instruction-fetch stage:
//   - default address / instruction widths, FIFO depth, outstanding limit
//   - sequential PC increment and reset fetch address
//   - fetch_entry_t: one prefetched instruction with its reported PC
//   - cnt_width(): width of a counter that must hold 0..max_val inclusive
// -----------------------------------------------------------------------------
package if_stage_prefetch_pkg;

  localparam int AW_DEF      = 32;
  localparam int IW_DEF      = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int MAX_OUT_DEF = 4;
  localparam int PC_INC_DEF  = 4;

  localparam logic [AW_DEF-1:0] RESET_PC_DEF = '0;

  // pc holds the fetch address + PC_INC, i.e. the value presented on out_pc.
  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [IW_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/if_stage_prefetch_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_stage_prefetch_fetch_fifo
// DEPTH-entry first-word-fall-through FIFO holding {pc, instr} entries.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : drop all contents this cycle (wins over push and pop)
//   push, push_data : write one entry (accepted when not full, or when a pop
//                 frees a slot in the same cycle)
//   pop         : remove the head entry (ignored when empty)
//   head_data   : current head entry, valid whenever empty = 0
//   count       : number of stored entries
//   empty       : no entries stored
// Entries are reset to zero so the head reads as zero straight out of reset.
// -----------------------------------------------------------------------------
module if_stage_prefetch_fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem_view [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign rd_en = pop & ~empty & ~flush;
  assign wr_en = push & ~flush & (~full | rd_en);

  assign head_data = mem_view[rd_ptr_reg];
  assign count     = count_reg;

  // One register per slot; each slot only loads when the write pointer
  // selects it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign mem_view[gi] = entry_reg;
    end
  endgenerate

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// -----------------------------------------------------------------------------
// if_stage_prefetch
// Instruction fetch stage with a DEPTH-entry prefetch FIFO.
//   clk, rst                    : clock, asynchronous active-high reset
//   branch_taken, branch_addr   : redirect pulse from EXE and its target
//   imem_req_valid/ready/addr   : fetch request channel to instruction memory
//   imem_rsp_valid/data         : in-order response channel, no back-pressure
//   out_valid/ready             : handshake to ID (out_ready = 0 freezes ID)
//   out_pc                      : fetch address of head instruction + PC_INC
//   out_instr                   : head instruction
// Requests are only issued while a FIFO slot is guaranteed for the response
// (fifo_count + outstanding < DEPTH), so responses never need back-pressure.
// A redirect flushes the FIFO and records how many responses still in flight
// belong to the old stream; those are discarded as they arrive.
// -----------------------------------------------------------------------------
module if_stage_prefetch
  import if_stage_prefetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            IW       = IW_DEF,
  parameter int            DEPTH    = DEPTH_DEF,
  parameter int            MAX_OUT  = MAX_OUT_DEF,
  parameter int            PC_INC   = PC_INC_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_addr,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [IW-1:0] out_instr
);

  localparam int OW = cnt_width(MAX_OUT);
  localparam int FW = cnt_width(DEPTH);
  localparam int SW = cnt_width(DEPTH + MAX_OUT);
  localparam int EW = AW + IW;

  logic [AW-1:0] fetch_pc_reg;
  logic [AW-1:0] rsp_pc_reg;
  logic [OW-1:0] outstanding_reg;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] drop_cnt_reg;

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_pop;
  logic [EW-1:0] fifo_push_data;
  logic [EW-1:0] fifo_head;
  logic [FW-1:0] fifo_count;
  logic          fifo_empty;

  // Credit: every issued request owns a FIFO slot until its response lands.
  assign credit_ok = ((SW'(fifo_count) + SW'(outstanding_reg)) < SW'(DEPTH)) &&
                     (outstanding_reg < OW'(MAX_OUT));

  assign imem_req_valid = credit_ok & ~rst;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign outstanding_next = outstanding_reg + OW'(req_fire) - OW'(imem_rsp_valid);

  // A response is kept only if it belongs to the current stream and no
  // redirect is happening this cycle.
  assign rsp_keep = imem_rsp_valid & (drop_cnt_reg == '0) & ~branch_taken;

  // Store the already-incremented PC so out_pc is a plain register read.
  assign fifo_push_data = {rsp_pc_reg + AW'(PC_INC), imem_rsp_data};

  assign fifo_pop  = out_valid & out_ready;
  assign out_valid = ~fifo_empty;
  assign out_pc    = fifo_head[EW-1:IW];
  assign out_instr = fifo_head[IW-1:0];

  if_stage_prefetch_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (rsp_keep),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;

      if (branch_taken) begin
        // Everything still in flight after this edge, including a request
        // firing now with the old PC, belongs to the abandoned stream.
        fetch_pc_reg <= branch_addr;
        rsp_pc_reg   <= branch_addr;
        drop_cnt_reg <= outstanding_next;
      end else begin
        if (req_fire) begin
          fetch_pc_reg <= fetch_pc_reg + AW'(PC_INC);
        end
        if (imem_rsp_valid) begin
          if (drop_cnt_reg != '0) begin
            drop_cnt_reg <= drop_cnt_reg - OW'(1);
          end else begin
            rsp_pc_reg <= rsp_pc_reg + AW'(PC_INC);
          end
        end
      end

      // Memory-side contract: no response without a request, and the credit
      // rule keeps a slot free for every kept response.
      if (imem_rsp_valid) begin
        assert (outstanding_reg != '0);
      end
      if (rsp_keep) begin
        assert (fifo_count < FW'(DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_stage_prefetch
// Directed bench for if_stage_prefetch with a behavioural in-order memory of
// programmable latency and a scoreboard of expected {out_pc, out_instr}.
// Expected entries are pushed when a request of the current stream fires and
// discarded when a redirect is driven; each handshake to ID pops one entry.
// -----------------------------------------------------------------------------
module tb_if_stage_prefetch;
  import if_stage_prefetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  if_stage_prefetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t        pend_q [$];
  fetch_entry_t exp_q  [$];
  logic [31:0]  exp_fetch_pc;
  int           exp_drop;
  bit           chk_drop;
  int           cyc;
  int           lat;
  int           delivered;
  int           fire_cnt;
  int           passes;
  int           fails;
  int           total;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Return at 1 time unit after the n-th falling edge, ready to drive.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    cycles(12);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: drives at most one in-order response per cycle once due.
  initial begin : memory
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: samples all handshakes for the upcoming rising edge.
  initial begin : monitor
    int           pend_before;
    bit           fire;
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        exp_fetch_pc = 32'h0;
        chk_drop     = 1'b0;
      end else begin
        pend_before = pend_q.size();
        if (chk_drop) begin
          check("drop_cnt", 32'(u_dut.drop_cnt_reg), exp_drop);
          chk_drop = 1'b0;
        end
        if (out_valid && out_ready && !branch_taken) begin
          delivered++;
          check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_instr", out_instr, e.instr);
            $display("deliver pc=%h instr=%h", out_pc, out_instr);
          end
        end
        fire = imem_req_valid && imem_req_ready;
        if (fire) begin
          fire_cnt++;
          check("req_addr", imem_req_addr, exp_fetch_pc);
          pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
          if (!branch_taken) begin
            e.pc    = exp_fetch_pc + 32'd4;
            e.instr = mem_word(exp_fetch_pc);
            exp_q.push_back(e);
          end
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (branch_taken) begin
          exp_drop     = pend_before + int'(fire);
          chk_drop     = 1'b1;
          exp_q.delete();
          exp_fetch_pc = branch_addr;
          $display("branch to %h drop=%0d", branch_addr, exp_drop);
        end
      end
    end
  end

  initial begin : stim
    passes = 0; fails = 0; total = 0;
    cyc = 0; lat = 1; delivered = 0; fire_cnt = 0;
    chk_drop = 1'b0; exp_drop = 0; exp_fetch_pc = 32'h0;
    rst = 1'b1; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_req_ready = 1'b1; out_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset state
    cycles(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b0;

    // Sequential fetch, latency 1, no back-pressure
    delivered = 0;
    cycles(20);
    check("seq_throughput", 32'(delivered >= 12), 32'd1);

    // ID frozen, latency 3: exactly DEPTH requests, then stall on credit
    drain();
    lat = 3; out_ready = 1'b0; imem_req_ready = 1'b1; fire_cnt = 0;
    cycles(20);
    check("freeze_req_count", fire_cnt, 32'd4);
    check("freeze_req_valid", 32'(imem_req_valid), 32'd0);
    check("freeze_fifo_count", 32'(u_dut.fifo_count), 32'd4);
    check("freeze_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; delivered = 0;
    cycles(20);
    check("unfreeze_progress", 32'(delivered >= 10), 32'd1);

    // Three requests in flight at latency 5, then redirect to 0x100
    drain();
    lat = 5; imem_req_ready = 1'b1; fire_cnt = 0;
    cycles(3);
    check("inflight_count", fire_cnt, 32'd3);
    branch_taken = 1'b1; branch_addr = 32'h100; imem_req_ready = 1'b0;
    cycles(1);
    branch_taken = 1'b0; imem_req_ready = 1'b1; delivered = 0;
    cycles(30);
    check("redirect_progress", 32'(delivered >= 10), 32'd1);

    // Redirect while a request fires and a response arrives
    lat = 2;
    cycles(6);
    check("busy_precond", 32'(imem_rsp_valid && imem_req_valid), 32'd1);
    branch_taken = 1'b1; branch_addr = 32'h180;
    cycles(1);
    branch_taken = 1'b0; delivered = 0;
    cycles(15);
    check("busy_branch_progress", 32'(delivered >= 5), 32'd1);

    // Back-to-back redirects: only the 0x300 stream survives
    branch_taken = 1'b1; branch_addr = 32'h200;
    cycles(1);
    branch_addr = 32'h300;
    cycles(1);
    branch_taken = 1'b0; delivered = 0;
    cycles(15);
    check("b2b_progress", 32'(delivered >= 5), 32'd1);

    // Random back-pressure, latency and occasional redirects
    for (int i = 0; i < 80; i++) begin
      out_ready      = 1'($urandom_range(0, 1));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      lat            = int'($urandom_range(1, 4));
      branch_taken   = ($urandom_range(0, 15) == 0);
      branch_addr    = 32'($urandom_range(0, 1023)) << 2;
      cycles(1);
    end
    branch_taken = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    cycles(10);

    // Address wrap-around
    lat = 1;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF8;
    cycles(1);
    branch_taken = 1'b0; delivered = 0;
    cycles(15);
    check("wrap_progress", 32'(delivered >= 8), 32'd1);

    // Asynchronous reset in the middle of the stream
    check("midrst_precond", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_out_pc", out_pc, 32'h0);
    cycles(2);
    rst = 1'b0; delivered = 0;
    cycles(15);
    check("post_rst_progress", 32'(delivered >= 8), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
- Parametrised successor to the single-cycle fetch stage: PC register, +PC_INC sequencer, branch redirect, plus a DEPTH-entry instruction prefetch FIFO.
- Talks to instruction memory over a valid/ready request channel and an in-order response channel with variable latency.
- Presents fetched instructions to the ID stage over a valid/ready handshake; ID back-pressure replaces the old freeze input.
- Branch redirect flushes the FIFO and silently discards responses still in flight.

Parameters:
- AW, 32, address/PC width in bits.
- IW, 32, instruction width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- MAX_OUT, 4, maximum outstanding memory requests; <= DEPTH.
- PC_INC, 4, sequential fetch increment.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- branch_taken  in  1  redirect request, single-cycle pulse from EXE.
- branch_addr  in  AW  redirect target, sampled when branch_taken=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  AW  fetch address (= fetch_pc).
- imem_rsp_valid  in  1  response valid; in order, no back-pressure.
- imem_rsp_data  in  IW  fetched instruction.
- out_valid  out  1  FIFO head valid to ID.
- out_ready  in  1  ID accepts (0 = freeze).
- out_pc  out  AW  fetch address of head + PC_INC (matches existing PC convention).
- out_instr  out  IW  head instruction.

Behaviour:
- Reset (async): fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0. Outputs: imem_req_valid=0 while rst=1, out_valid=0, out_pc=0, out_instr=0.
- Request firing: req_fire = imem_req_valid & imem_req_ready. On fire, fetch_pc += PC_INC (mod 2^AW) and outstanding++.
- Credit rule: imem_req_valid=1 iff fifo_count + outstanding < DEPTH and outstanding < MAX_OUT. This guarantees every response has a slot.
- Response (imem_rsp_valid=1): outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Otherwise: push {addr, data} into the FIFO. The address is tracked by a per-request address queue, or by a rsp_pc register advanced by PC_INC.
- Pop: out_valid & out_ready. Push and pop in the same cycle keep fifo_count unchanged.
- Response latency: minimum 1 cycle. out_valid rises the cycle after the first non-dropped response; no combinational path from imem_rsp_* to out_*.
- Branch (highest priority), in the cycle branch_taken=1:
  - FIFO cleared; any pop that cycle is ignored; out_valid=0 next cycle.
  - fetch_pc <= branch_addr.
  - drop_cnt <= outstanding + req_fire - imem_rsp_valid. A request firing in the branch cycle uses the old PC and is dropped; a response arriving in the branch cycle is discarded.
  - rsp_pc <= branch_addr.
- Back-to-back branches: the latest branch wins; drop_cnt is recomputed from the current outstanding.
- Full FIFO with out_ready=0: requests stall by credit; no overflow possible. A response arriving when the FIFO is full is an assertion failure.
- Empty FIFO: out_valid=0; out_pc/out_instr hold their last value (don't-care for checking).
- Wrap-around: fetch_pc at 2^AW-PC_INC wraps to 0.
- Reset mid-operation: all state cleared immediately. Responses for pre-reset requests are a memory-side contract violation; the memory must be reset together with this block.

Decomposition:
- Shared package: AW/IW defaults, PC_INC, RESET_PC, and a fetch-entry struct {pc, instr}.
- Sub-module fetch_fifo (DEPTH, width AW+IW), with push/pop/flush/count and simultaneous push+pop support.
- Counters, credit logic and redirect stay in the top.

Test Plan:
- Reset, imem latency 1, out_ready=1 -> requests at 0x0, 0x4, 0x8…; out_pc sequence 0x4, 0x8, 0xC; out_instr matches memory words.
- out_ready=0 for 20 cycles, latency 3 -> exactly DEPTH=4 requests issued; FIFO holds 4; no requests until pops resume; no instruction lost.
- 3 requests in flight (latency 5), branch_taken with branch_addr=0x100 -> the 3 responses are discarded; next out_pc=0x104 with instr at 0x100.
- branch_taken in a cycle with req_fire and imem_rsp_valid both 1 -> drop_cnt equals pre-branch outstanding; no stale instruction reaches ID.
- Two branches on consecutive cycles (0x200, then 0x300) -> only 0x300-stream instructions are delivered.
- fetch_pc=0xFFFFFFFC, AW=32 -> next request address 0x0; asserting rst mid-stream -> out_valid=0 and imem_req_valid=0 asynchronously.
